regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
// PURPOSE
//  Write-side companion to registerFile: buffers retiring results (rd, data) in a small FIFO.
//  Drains at most one entry per cycle into the register file write port (RD/WriteData/RegWrite).
//  Forwards still-pending data to the read ports (RS1/RS2) so readers never see stale values.
//  Sits between the execute/load writeback sources and registerFile.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >= 2
//  XLEN    64  data width
//  AW      5   register address width (32 registers)
// PORTS
//  clk        in   1            single clock, posedge
//  reset      in   1            asynchronous, active-high; clears all state
//  wb_valid   in   1            writeback request valid
//  wb_ready   out  1            queue can accept; combinational = (count != DEPTH)
//  wb_rd      in   AW           destination register
//  wb_data    in   XLEN         result value
//  rf_hold    in   1            1 = do not drain this cycle (write port borrowed)
//  RD         out  AW           to registerFile.RD (registered)
//  WriteData  out  XLEN         to registerFile.WriteData (registered)
//  RegWrite   out  1            to registerFile.RegWrite (registered)
//  RS1, RS2   in   AW           read addresses also driven to registerFile
//  fwd1_hit   out  1            pending write to RS1 exists (combinational)
//  fwd1_data  out  XLEN         youngest pending value for RS1
//  fwd2_hit   out  1            as fwd1, for RS2
//  fwd2_data  out  XLEN
//  count      out  $clog2(DEPTH+1)  queue occupancy (excludes the output stage)
// BEHAVIOUR
//  Reset: count=0, rd/wr pointers=0, RD=0, WriteData=0, RegWrite=0, fwd*_hit=0, fwd*_data=0.
//  Accept: handshake at posedge when wb_valid & wb_ready; entry written at wr_ptr, wr_ptr++.
//  x0: wb_rd==0 handshakes normally but is discarded (no enqueue, count unchanged, never on RD).
//  Drain: at posedge, if count>0 & !rf_hold -> head popped into RD/WriteData, RegWrite<=1;
//   otherwise RegWrite<=0 (RD/WriteData hold previous value).
//  Latency: accept at edge N -> RegWrite=1 during cycle after edge N+1 -> regfile writes at N+2.
//   An entry accepted at edge N is never popped at edge N (no same-edge pass-through).
//  Simultaneous accept+pop: count unchanged, both pointers advance.
//  Full (count==DEPTH): wb_ready=0; request must hold until accepted. No overflow possible.
//  Empty: RegWrite<=0 each edge; no underflow.
//  Pointers wrap modulo DEPTH; count saturates by construction (guarded, never >DEPTH).
//  Forwarding (per read port, combinational): search output stage (if RegWrite) and all valid
//   queue entries; youngest matching rd wins (newest queue entry > older > output stage).
//   RSx==0 -> hit=0, data=0. Incoming wb_* of the current cycle is NOT searched.
//  Program order preserved: two writes to same rd drain in accept order; last one wins in RF.
//  Reset mid-operation: all pending writes dropped, RegWrite deasserts immediately (async).
//  rf_hold: may toggle any cycle; queue keeps accepting while held until full.
// STRUCTURE
//  Shared package rv_regfile_pkg: XLEN=64, AW=5, NUM_REGS=32, ZERO_REG=5'd0,
//   typedef wb_entry_t {rd[AW-1:0], data[XLEN-1:0]}.
//  Sub-module regfile_wq_match: youngest-match priority search over DEPTH+1 entries
//   (valid mask, ages from rd_ptr); instantiated twice (RS1, RS2).
//  Top keeps FIFO storage, pointers, count, output stage.
// TESTING
//  1 wb x9=100, rf_hold=0 -> next cycle RegWrite=1, RD=9, WriteData=100; RS1=9 reads 100 after.
//  2 x9=100 then x9=250 with rf_hold=1, RS1=9 -> fwd1_hit=1, fwd1_data=250; release: 100 then 250.
//  3 rf_hold=1, push x1..x4 -> count=4, wb_ready=0; x5 held until 1 pop, then accepted.
//  4 wb x0=100 -> handshake completes, count stays 0, RegWrite never 1, RS2=0 -> fwd2_hit=0.
//  5 count=2, push+pop same edge -> count=2, order preserved (x3,x4,x5 drain in order).
//  6 three entries pending, pulse reset mid-cycle -> RegWrite=0 at once, count=0, no RF write.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// Shared register-file write-side types: widths and the queued writeback entry.
package rv_regfile_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [AW-1:0] ZERO_REG = AW'(0);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wq_match.sv
// Youngest-match search over the output stage plus the live queue entries for one read port.
module regfile_wq_match
    import rv_regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t                      out_i,
    input  logic                           out_valid_i,
    input  wb_entry_t                      mem_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]       rd_ptr_i,
    input  logic [$clog2(DEPTH+1)-1:0]     count_i,
    input  logic [AW-1:0]                  rs_i,
    output logic                           hit_o,
    output logic [XLEN-1:0]                data_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (rs_i != ZERO_REG) begin
            if (out_valid_i && (out_i.rd == rs_i)) begin
                hit_o  = 1'b1;
                data_o = out_i.data;
            end
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if ((CW'(k) < count_i) && (mem_i[rd_ptr_i + PW'(k)].rd == rs_i)) begin
                    hit_o  = 1'b1;
                    data_o = mem_i[rd_ptr_i + PW'(k)].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Writeback FIFO in front of the register file write port, with read-port forwarding
// of pending values so readers never observe a stale register.
module regfile_write_queue
    import rv_regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [AW-1:0]                wb_rd,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         rf_hold,
    output logic [AW-1:0]                RD,
    output logic [XLEN-1:0]              WriteData,
    output logic                         RegWrite,
    input  logic [AW-1:0]                RS1,
    input  logic [AW-1:0]                RS2,
    output logic                         fwd1_hit,
    output logic [XLEN-1:0]              fwd1_data,
    output logic                         fwd2_hit,
    output logic [XLEN-1:0]              fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    wb_entry_t       out_q, out_d;
    logic            regwrite_q, regwrite_d;
    logic            push_c, pop_c;

    assign wb_ready = (count_q != CW'(DEPTH));
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push_c   = wb_valid && wb_ready && (wb_rd != ZERO_REG);
    assign pop_c    = (count_q != CW'(0)) && !rf_hold;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        regwrite_d = 1'b0;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            out_d      = mem_q[rd_ptr_q];
            regwrite_d = 1'b1;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            regwrite_q <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            regwrite_q <= regwrite_d;
            if (push_c) begin
                mem_q[wr_ptr_q] <= '{rd: wb_rd, data: wb_data};
            end
        end
    end

    assign RD        = out_q.rd;
    assign WriteData = out_q.data;
    assign RegWrite  = regwrite_q;
    assign count     = count_q;

    regfile_wq_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .out_i       (out_q),
        .out_valid_i (regwrite_q),
        .mem_i       (mem_q),
        .rd_ptr_i    (rd_ptr_q),
        .count_i     (count_q),
        .rs_i        (RS1),
        .hit_o       (fwd1_hit),
        .data_o      (fwd1_data)
    );

    regfile_wq_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .out_i       (out_q),
        .out_valid_i (regwrite_q),
        .mem_i       (mem_q),
        .rd_ptr_i    (rd_ptr_q),
        .count_i     (count_q),
        .rs_i        (RS2),
        .hit_o       (fwd2_hit),
        .data_o      (fwd2_data)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: per-cycle vector table plus backpressure and reset sequences.
module tb_regfile_write_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        rf_hold = 1'b0;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [4:0]  RS1 = '0;
    logic [4:0]  RS2 = '0;
    logic        fwd1_hit;
    logic [63:0] fwd1_data;
    logic        fwd2_hit;
    logic [63:0] fwd2_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rf_hold   (rf_hold),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .RS1       (RS1),
        .RS2       (RS2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        hold;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ready;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [63:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_h1;
        logic [63:0] e_d1;
        logic        e_h2;
        logic [63:0] e_d2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int v, input int rd, input int data, input int hold,
                                input int rs1, input int rs2, input int e_ready, input int e_rw,
                                input int e_rd, input int e_wd, input int e_cnt,
                                input int e_h1, input int e_d1, input int e_h2, input int e_d2);
        vec_t t;
        t.v = 1'(v);       t.rd = 5'(rd);       t.data = 64'(data);  t.hold = 1'(hold);
        t.rs1 = 5'(rs1);   t.rs2 = 5'(rs2);     t.e_ready = 1'(e_ready);
        t.e_rw = 1'(e_rw); t.e_rd = 5'(e_rd);   t.e_wd = 64'(e_wd);  t.e_cnt = 3'(e_cnt);
        t.e_h1 = 1'(e_h1); t.e_d1 = 64'(e_d1);  t.e_h2 = 1'(e_h2);   t.e_d2 = 64'(e_d2);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   accept_cyc;
        logic acc;
        logic [4:0]  rds[$];
        logic [63:0] wds[$];

        // columns: v rd data hold rs1 rs2 | ready rw RD WD count h1 d1 h2 d2
        vecs.push_back(mk(1, 9, 100, 0, 9, 0,  1, 0, 0, 0,   0,  0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 9, 0,  1, 0, 0, 0,   1,  1, 100, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 9, 0,  1, 1, 9, 100, 0,  1, 100, 0, 0));
        vecs.push_back(mk(1, 9, 100, 1, 9, 0,  1, 0, 9, 100, 0,  0, 0,   0, 0));
        vecs.push_back(mk(1, 9, 250, 1, 9, 0,  1, 0, 9, 100, 1,  1, 100, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 9, 0,  1, 0, 9, 100, 2,  1, 250, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 9, 0,  1, 0, 9, 100, 2,  1, 250, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 9, 0,  1, 1, 9, 100, 1,  1, 250, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 9, 0,  1, 1, 9, 250, 0,  1, 250, 0, 0));
        vecs.push_back(mk(1, 0, 100, 0, 9, 0,  1, 0, 9, 250, 0,  0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0,  1, 0, 9, 250, 0,  0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0,  1, 0, 9, 250, 0,  0, 0,   0, 0));
        vecs.push_back(mk(1, 3, 33,  1, 3, 4,  1, 0, 9, 250, 0,  0, 0,   0, 0));
        vecs.push_back(mk(1, 4, 44,  1, 3, 4,  1, 0, 9, 250, 1,  1, 33,  0, 0));
        vecs.push_back(mk(1, 5, 55,  0, 3, 5,  1, 0, 9, 250, 2,  1, 33,  0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 3, 5,  1, 1, 3, 33,  2,  1, 33,  1, 55));
        vecs.push_back(mk(0, 0, 0,   0, 4, 5,  1, 1, 4, 44,  1,  1, 44,  1, 55));
        vecs.push_back(mk(0, 0, 0,   0, 4, 5,  1, 1, 5, 55,  0,  0, 0,   1, 55));
        vecs.push_back(mk(0, 0, 0,   0, 4, 5,  1, 0, 5, 55,  0,  0, 0,   0, 0));

        // Reset state
        RS1 = 5'd9;
        RS2 = 5'd9;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst RegWrite", 64'(RegWrite), 64'd0);
        chk("rst RD", 64'(RD), 64'd0);
        chk("rst WriteData", WriteData, 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst wb_ready", 64'(wb_ready), 64'd1);
        chk("rst fwd1_hit", 64'(fwd1_hit), 64'd0);
        chk("rst fwd2_data", fwd2_data, 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            wb_valid = vecs[i].v;
            wb_rd    = vecs[i].rd;
            wb_data  = vecs[i].data;
            rf_hold  = vecs[i].hold;
            RS1      = vecs[i].rs1;
            RS2      = vecs[i].rs2;
            @(negedge clk);
            chk($sformatf("v%0d wb_ready", i), 64'(wb_ready), 64'(vecs[i].e_ready));
            chk($sformatf("v%0d RegWrite", i), 64'(RegWrite), 64'(vecs[i].e_rw));
            chk($sformatf("v%0d RD", i), 64'(RD), 64'(vecs[i].e_rd));
            chk($sformatf("v%0d WriteData", i), WriteData, vecs[i].e_wd);
            chk($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d fwd1_hit", i), 64'(fwd1_hit), 64'(vecs[i].e_h1));
            chk($sformatf("v%0d fwd1_data", i), fwd1_data, vecs[i].e_d1);
            chk($sformatf("v%0d fwd2_hit", i), 64'(fwd2_hit), 64'(vecs[i].e_h2));
            chk($sformatf("v%0d fwd2_data", i), fwd2_data, vecs[i].e_d2);
            tick();
        end
        wb_valid = 1'b0;

        // Fill to DEPTH under hold, then a held request waits for the first pop
        rf_hold = 1'b1;
        RS1 = 5'd2;
        RS2 = 5'd5;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'(i);
            wb_data  = 64'(i * 11);
            @(negedge clk);
            chk($sformatf("fill%0d wb_ready", i), 64'(wb_ready), 64'd1);
            tick();
        end
        wb_rd   = 5'd5;
        wb_data = 64'd55;
        @(negedge clk);
        chk("full count", 64'(count), 64'd4);
        chk("full wb_ready", 64'(wb_ready), 64'd0);
        chk("full fwd1_data", fwd1_data, 64'd22);
        chk("full fwd2_hit incoming", 64'(fwd2_hit), 64'd0);
        tick();
        @(negedge clk);
        chk("held count", 64'(count), 64'd4);
        chk("held wb_ready", 64'(wb_ready), 64'd0);
        chk("held RegWrite", 64'(RegWrite), 64'd0);
        tick();

        rf_hold    = 1'b0;
        accept_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (RegWrite) begin
                rds.push_back(RD);
                wds.push_back(WriteData);
            end
            acc = wb_valid && wb_ready;
            if (acc) accept_cyc = c;
            tick();
            if (acc) wb_valid = 1'b0;
        end
        chk("bp accept cycle", 64'(accept_cyc), 64'd1);
        chk("bp drain writes", 64'(rds.size()), 64'd5);
        for (int k = 0; k < rds.size(); k++) begin
            chk($sformatf("bp drain%0d RD", k), 64'(rds[k]), 64'(k + 1));
            chk($sformatf("bp drain%0d WriteData", k), wds[k], 64'((k + 1) * 11));
        end
        @(negedge clk);
        chk("bp final count", 64'(count), 64'd0);
        tick();

        // Asynchronous reset with writes pending and one in the output stage
        rf_hold = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'(i);
            wb_data  = 64'(i * 10);
            tick();
        end
        wb_valid = 1'b0;
        rf_hold  = 1'b0;
        RS1 = 5'd8;
        RS2 = 5'd7;
        tick();
        chk("pre-rst RegWrite", 64'(RegWrite), 64'd1);
        chk("pre-rst count", 64'(count), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("async RegWrite", 64'(RegWrite), 64'd0);
        chk("async count", 64'(count), 64'd0);
        chk("async RD", 64'(RD), 64'd0);
        chk("async WriteData", WriteData, 64'd0);
        chk("async fwd1_hit", 64'(fwd1_hit), 64'd0);
        chk("async fwd2_hit", 64'(fwd2_hit), 64'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst%0d RegWrite", c), 64'(RegWrite), 64'd0);
            chk($sformatf("post-rst%0d count", c), 64'(count), 64'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
